fetch_queue: RTL

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue.sv | 88 ++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch queue. It issues sequential imem reads against a credit check and buffers the
// returned words with their next-PC. The head entry is presented to decode, and a redirect flushes the queue.
module fetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic [31:0]              address_imem,
  input  logic [31:0]              q_imem,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     insn_ready,
  output logic                     insn_valid,
  output logic [31:0]              insn,
  output logic [31:0]              insn_npc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   r_fetch_pc;
  logic          r_inflight;
  logic [31:0]   r_inflight_pc;
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [31:0]   r_q_insn [DEPTH];
  logic [31:0]   r_q_npc  [DEPTH];

  logic [CW:0]   w_credit;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;

  // An outstanding fetch holds a slot, so the queue can never be pushed while full.
  assign w_credit = {1'b0, r_count} + {{CW{1'b0}}, r_inflight};
  assign w_issue  = !redirect && (w_credit < (CW+1)'(DEPTH));
  assign w_valid  = (r_count != '0);
  assign w_push   = r_inflight && !redirect;
  assign w_pop    = w_valid && insn_ready && !redirect;

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_fetch_pc    <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_head        <= '0;
      r_tail        <= '0;
      r_count       <= '0;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
      r_inflight <= 1'b0;
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + 32'd1;
      end
      if (w_push) r_tail <= r_tail + AW'(1);
      if (w_pop)  r_head <= r_head + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage needs no reset; the count alone decides which entries are live.
  always_ff @(posedge clock) begin
    if (reset && w_push) begin
      r_q_insn[r_tail] <= q_imem;
      r_q_npc[r_tail]  <= r_inflight_pc + 32'd1;
    end
  end

  assign address_imem = r_fetch_pc;
  assign insn_valid   = w_valid;
  assign insn         = w_valid ? r_q_insn[r_head] : 32'd0;
  assign insn_npc     = w_valid ? r_q_npc[r_head]  : 32'd0;
  assign occupancy    = r_count;

endmodule
